fft_agu: RTL and testbench

FFT_AGU -- requirements
Module: fft_agu

---
 rtl/fft_agu_if.sv | 29 ++
 rtl/fft_agu.sv | 121 ++++++++++++
 tb/tb_fft_agu.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_agu_if.sv
// Bus between the FFT address generator and the datapath that owns the sample memory,
// twiddle ROM and butterfly.
interface fft_agu_if #(
  parameter int unsigned N_LOG2 = 5
) ();
  logic              start;
  logic [N_LOG2-1:0] rd_adrA;
  logic [N_LOG2-1:0] rd_adrB;
  logic [N_LOG2-2:0] twiddle_adr;
  logic              rd_bank;
  logic [N_LOG2-1:0] wr_adrA;
  logic [N_LOG2-1:0] wr_adrB;
  logic              wr_bank;
  logic              we;
  logic              busy;
  logic              done;

  modport master (
    output start,
    input  rd_adrA, rd_adrB, twiddle_adr, rd_bank,
    input  wr_adrA, wr_adrB, wr_bank, we, busy, done
  );

  modport slave (
    input  start,
    output rd_adrA, rd_adrB, twiddle_adr, rd_bank,
    output wr_adrA, wr_adrB, wr_bank, we, busy, done
  );
endinterface

// File: rtl/fft_agu.sv
// Address generator for an in-place radix-2 DIT FFT: one butterfly per cycle, ping-pong banks,
// write-back addresses trailing the reads by one cycle to match a synchronous-read memory.
module fft_agu #(
  parameter int unsigned N_LOG2 = 5
) (
  input logic       clk,
  input logic       reset,
  fft_agu_if.slave  bus
);

  localparam int unsigned JW = N_LOG2 - 1;
  localparam int unsigned SW = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
  localparam logic [SW-1:0] LastStage = SW'(N_LOG2 - 1);
  localparam logic [JW-1:0] LastJ     = {JW{1'b1}};

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e            state_q;
  logic [SW-1:0]     stage_q;
  logic [JW-1:0]     j_q;
  logic              busy_q;
  logic              done_q;
  logic              we_q;
  logic              wr_bank_q;
  logic [N_LOG2-1:0] wr_a_q;
  logic [N_LOG2-1:0] wr_b_q;

  logic              in_run;
  logic [N_LOG2-1:0] ja;
  logic [N_LOG2-1:0] jb;
  logic [SW:0]       rsh;
  logic [N_LOG2-1:0] rd_a;
  logic [N_LOG2-1:0] rd_b;
  logic [JW-1:0]     tw_mask;
  logic [JW-1:0]     tw;
  logic              rbank;

  // Read side is purely combinational from the counters and forced to zero outside RUN.
  always_comb begin
    in_run  = (state_q == StRun);
    ja      = {j_q, 1'b0};
    jb      = {j_q, 1'b1};
    rsh     = (SW + 1)'(N_LOG2) - {1'b0, stage_q};
    tw_mask = LastJ << (LastStage - stage_q);
    rd_a    = '0;
    rd_b    = '0;
    tw      = '0;
    rbank   = 1'b0;
    if (in_run) begin
      // Rotate-left by stage: a shift by N_LOG2 in stage 0 yields zero, so no special case.
      rd_a  = (ja << stage_q) | (ja >> rsh);
      rd_b  = (jb << stage_q) | (jb >> rsh);
      tw    = j_q & tw_mask;
      rbank = stage_q[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      stage_q   <= '0;
      j_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      wr_bank_q <= 1'b0;
      wr_a_q    <= '0;
      wr_b_q    <= '0;
    end else begin
      we_q      <= in_run;
      wr_a_q    <= rd_a;
      wr_b_q    <= rd_b;
      wr_bank_q <= in_run & ~rbank;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StRun;
            stage_q <= '0;
            j_q     <= '0;
            busy_q  <= 1'b1;
          end
        end
        StRun: begin
          if (j_q == LastJ) begin
            j_q <= '0;
            if (stage_q == LastStage) begin
              state_q <= StFlush;
              stage_q <= '0;
            end else begin
              stage_q <= stage_q + 1'b1;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        StFlush: begin
          state_q <= StDone;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rd_adrA     = rd_a;
  assign bus.rd_adrB     = rd_b;
  assign bus.twiddle_adr = tw;
  assign bus.rd_bank     = rbank;
  assign bus.wr_adrA     = wr_a_q;
  assign bus.wr_adrB     = wr_b_q;
  assign bus.wr_bank     = wr_bank_q;
  assign bus.we          = we_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_fft_agu.sv
// Self-checking bench for fft_agu: fixed address vectors, start/reset corner sequences and
// randomized start/abort traffic checked against a cycle-position model of the transform.
module tb_fft_agu;

  localparam int NL      = 5;
  localparam int N       = 32;
  localparam int HALF    = 16;
  localparam int RUN_LEN = NL * HALF;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   mk;  // -1 idle, else cycles elapsed since the start edge (0 = first butterfly)

  fft_agu_if #(.N_LOG2(NL)) bus ();

  fft_agu #(.N_LOG2(NL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] rot(int x, int s);
    return 5'(((x << s) | (x >> (NL - s))) % N);
  endfunction

  function automatic logic [28:0] model_out(int k);
    logic [4:0] ra, rb, wa, wb;
    logic [3:0] tw;
    logic       rbk, wbk, we, busy, done;
    int         s, j, ps, pj;
    ra = '0; rb = '0; wa = '0; wb = '0; tw = '0;
    rbk = 1'b0; wbk = 1'b0; we = 1'b0;
    if (k >= 0 && k < RUN_LEN) begin
      s   = k / HALF;
      j   = k % HALF;
      ra  = rot(2 * j, s);
      rb  = rot(2 * j + 1, s);
      tw  = 4'((j >> (NL - 1 - s)) << (NL - 1 - s));
      rbk = (s % 2) == 1;
    end
    if (k >= 1 && k <= RUN_LEN) begin
      ps  = (k - 1) / HALF;
      pj  = (k - 1) % HALF;
      wa  = rot(2 * pj, ps);
      wb  = rot(2 * pj + 1, ps);
      wbk = (ps % 2) == 0;
      we  = 1'b1;
    end
    busy = (k >= 0 && k <= RUN_LEN);
    done = (k == RUN_LEN + 1);
    return {ra, rb, tw, rbk, wa, wb, wbk, we, busy, done};
  endfunction

  function automatic logic [28:0] dut_out();
    return {bus.rd_adrA, bus.rd_adrB, bus.twiddle_adr, bus.rd_bank, bus.wr_adrA, bus.wr_adrB,
            bus.wr_bank, bus.we, bus.busy, bus.done};
  endfunction

  task automatic check_model(string name);
    logic [28:0] exp, got;
    exp = model_out(mk);
    got = dut_out();
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s k=%0d got=%h expected=%h", name, mk, got, exp);
    end
  endtask

  task automatic check_val(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // One clock edge; the model advances with the inputs that were in effect at the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset)                 mk = -1;
    else if (mk < 0)            mk = bus.start ? 0 : -1;
    else if (mk == RUN_LEN + 1) mk = -1;
    else                        mk++;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    mk    = -1;
    #1;
    check_model("reset_state");
    tick();
    reset = 1'b1;
  endtask

  typedef struct {
    int         stage;
    int         j;
    logic [4:0] a;
    logic [4:0] b;
    logic [3:0] tw;
    logic       bank;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int we_cnt, busy_cnt, done_cnt, done_at;
    tests = 0;
    fails = 0;
    mk    = -1;
    reset = 1'b0;
    bus.start = 1'b0;

    vecs[0] = '{stage: 0, j: 0,  a: 5'd0,  b: 5'd1,  tw: 4'd0,  bank: 1'b0};
    vecs[1] = '{stage: 2, j: 5,  a: 5'd9,  b: 5'd13, tw: 4'd4,  bank: 1'b0};
    vecs[2] = '{stage: 1, j: 1,  a: 5'd4,  b: 5'd6,  tw: 4'd0,  bank: 1'b1};
    vecs[3] = '{stage: 4, j: 15, a: 5'd15, b: 5'd31, tw: 4'd15, bank: 1'b0};
    vecs[4] = '{stage: 3, j: 2,  a: 5'd1,  b: 5'd9,  tw: 4'd2,  bank: 1'b1};
    vecs[5] = '{stage: 1, j: 7,  a: 5'd28, b: 5'd30, tw: 4'd0,  bank: 1'b1};

    #2;
    check_val("reset_busy", 32'(bus.busy), 0);
    check_val("reset_we", 32'(bus.we), 0);
    apply_reset();
    tick();
    check_model("idle_after_reset");

    // Address vectors: reach the butterfly, check reads, then the write-back one cycle later.
    foreach (vecs[v]) begin
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check_model("vec_walk");
      for (int c = 0; c < vecs[v].stage * HALF + vecs[v].j; c++) begin
        tick();
        check_model("vec_walk");
      end
      check_val($sformatf("vec%0d_rd_adrA", v), 32'(bus.rd_adrA), 32'(vecs[v].a));
      check_val($sformatf("vec%0d_rd_adrB", v), 32'(bus.rd_adrB), 32'(vecs[v].b));
      check_val($sformatf("vec%0d_twiddle", v), 32'(bus.twiddle_adr), 32'(vecs[v].tw));
      check_val($sformatf("vec%0d_rd_bank", v), 32'(bus.rd_bank), 32'(vecs[v].bank));
      tick();
      check_val($sformatf("vec%0d_wr_adrA", v), 32'(bus.wr_adrA), 32'(vecs[v].a));
      check_val($sformatf("vec%0d_wr_adrB", v), 32'(bus.wr_adrB), 32'(vecs[v].b));
      check_val($sformatf("vec%0d_wr_bank", v), 32'(bus.wr_bank), 32'(!vecs[v].bank));
      check_val($sformatf("vec%0d_we", v), 32'(bus.we), 1);
      apply_reset();
    end

    // Full transform: 80 writes, busy through FLUSH, done 82 cycles after the start edge.
    we_cnt = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      check_model("full_run");
      if (bus.we)   we_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin done_cnt++; done_at = c; end
      tick();
    end
    check_val("full_we_count", 32'(we_cnt), RUN_LEN);
    check_val("full_busy_count", 32'(busy_cnt), RUN_LEN + 1);
    check_val("full_done_count", 32'(done_cnt), 1);
    check_val("full_done_cycle", 32'(done_at), RUN_LEN + 2);

    // Start held through the run and the DONE cycle: one done, no restart once start drops.
    done_cnt = 0;
    bus.start = 1'b1;
    for (int c = 0; c < 120 && done_cnt == 0; c++) begin
      tick();
      check_model("held_start");
      if (bus.done) done_cnt++;
    end
    tick();
    bus.start = 1'b0;
    check_model("held_idle");
    busy_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_model("held_after");
      if (bus.busy || bus.done) busy_cnt++;
    end
    check_val("held_done_count", 32'(done_cnt), 1);
    check_val("held_no_restart", 32'(busy_cnt), 0);
    // Start still high when IDLE samples it launches a second transform.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val("restart_busy", 32'(bus.busy), 1);
    apply_reset();

    // Abort at stage 2, j=7: outputs clear at once, nothing trails the release, restart is clean.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 0; c < 2 * HALF + 7; c++) tick();
    check_val("abort_pos_rdA", 32'(bus.rd_adrA), 32'(rot(14, 2)));
    reset = 1'b0;
    mk    = -1;
    #1;
    check_val("abort_outputs", 32'(dut_out()), 0);
    tick();
    reset = 1'b1;
    we_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_model("abort_release");
      if (bus.we || bus.done || bus.busy) we_cnt++;
    end
    check_val("abort_no_trailing", 32'(we_cnt), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val("abort_restart_rdA", 32'(bus.rd_adrA), 0);
    check_val("abort_restart_rdB", 32'(bus.rd_adrB), 1);
    apply_reset();

    // Randomized start widths, idle gaps and aborts, checked every cycle against the model.
    for (int it = 0; it < 8; it++) begin
      int gap, hold, abort_at;
      bit abort;
      gap      = $urandom_range(0, 4);
      hold     = $urandom_range(1, 100);
      abort    = ($urandom_range(0, 2) == 0);
      abort_at = $urandom_range(1, 85);
      for (int c = 0; c < gap; c++) begin
        tick();
        check_model("rand_gap");
      end
      bus.start = 1'b1;
      for (int c = 0; c < 120; c++) begin
        tick();
        check_model("rand_run");
        if (c == hold - 1) bus.start = 1'b0;
        if (abort && c == abort_at) begin
          reset = 1'b0;
          mk    = -1;
          #1;
          check_model("rand_abort");
          tick();
          reset = 1'b1;
        end
      end
      bus.start = 1'b0;
      for (int c = 0; c < 100 && mk >= 0; c++) begin
        tick();
        check_model("rand_drain");
      end
      check_val("rand_idle", 32'(bus.busy), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
